sm4_eth_fcs_regen: RTL and testbench
====================================

# sm4_eth_fcs_regen

Downstream stage of the SM4 Ethernet datapath. It consumes the byte stream produced by the 42-byte-offset SM4 encrypt/decrypt stage, where the payload has been rewritten and the trailing 4-byte FCS is stale. It recomputes the Ethernet CRC-32 over every byte except the last four, replaces those four with the fresh FCS, and forwards the frame with no backpressure.

## Interface
- `SYNC_ON_RST`, default 0: 1 = after reset, discard input up to and including the first `tlast` beat.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  8  frame byte (upstream output of the SM4 stage).
- `s_axis_tvalid`  in  1  byte valid; there is no ready, so every valid beat is accepted.
- `s_axis_tlast`  in  1  last byte of frame (the final byte of the old FCS).
- `s_axis_tuser`  in  8  per-byte sideband, carried through.
- `m_axis_tdata`  out  8  frame byte with regenerated FCS.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tlast`  out  1  last FCS byte.
- `m_axis_tuser`  out  8  per-byte sideband.
- `runt_drop`  out  1  one-cycle pulse when a frame of 4 bytes or fewer is dropped.

## Operation
- 4-entry hold buffer stores data and tuser, with a fill count `hcnt` (0..4).
- On an accepted beat with `hcnt`==4, the oldest entry is emitted as payload and the new beat is shifted in. Otherwise the beat is shifted in and `hcnt` increments.
- CRC-32 is reflected: poly 0xEDB88320, init 0xFFFFFFFF. It updates byte-wise on each emitted payload byte only.
- On a `tlast` beat with `hcnt`==4:
  - emit the oldest entry as the last payload byte;
  - latch FCS = ~crc_next, computed including that byte;
  - reset the CRC to init;
  - clear the buffer (`hcnt`=0);
  - enter EMIT.
- On a `tlast` beat with `hcnt`<4 (frame length ≤4): clear the buffer, output nothing, pulse `runt_drop`.
- FSM states:
  - SYNC: entered from reset only if `SYNC_ON_RST`=1. Drops beats and exits to IDLE on the dropped `tlast` beat.
  - IDLE/STREAM: normal operation as above.
  - EMIT: 4 consecutive cycles, unconditional. Outputs FCS[7:0], [15:8], [23:16], [31:24]. `m_axis_tlast`=1 on the 4th. Then returns to STREAM.
- During EMIT, new-frame beats keep shifting into the emptied buffer. With `hcnt`<4 they generate no output, so output never collides.
- FCS bytes carry the tuser of the old FCS byte they replace. This is captured from the buffer plus the `tlast` beat at the `tlast` edge.
- Gaps (`s_axis_tvalid`=0) inside a frame stall the buffer. Output stays idle except during EMIT.

## Timing
- Reset values: all `m_axis_*`=0, `runt_drop`=0, `hcnt`=0, CRC=0xFFFFFFFF, state IDLE (or SYNC).
- Outputs are registered. The byte for beat n appears the cycle after the edge accepting beat n+4 of the same frame.
- `tlast` beat accepted at edge t:
  - last payload byte valid after t;
  - FCS bytes valid after t+1..t+4;
  - `m_axis_tlast` after t+4.
- The next frame's first output is no earlier than after t+5, since 5 new beats are needed.
- `m_axis_tvalid` is high for exactly L cycles per frame of length L≥5. The output frame length equals the input frame length.
- Back-to-back frames with no gap are sustained indefinitely.
- `rst_n` asserted mid-frame or mid-EMIT: immediate clear. The partial output frame is truncated with no `tlast`.

## Structure
- Shared package: CRC32 polynomial, init, and residue 0xDEBB20E3 constants; FSM state encoding; byte-wise CRC function `crc32_byte(crc, d)`.
- One natural sub-module: `eth_crc32_d8` (combinational byte CRC step), reusable by future FCS-check stages.

## Test plan
- Frame "123456789" plus 4 arbitrary bytes (13 bytes) -> output bytes 0–8 unchanged, then 0x26, 0x39, 0xF4, 0xCB, with `tlast` on 0xCB.
- 64-byte frame with random payload and garbage FCS -> CRC register over the full output frame (not inverted) equals 0xDEBB20E3; output length 64.
- Three 64-byte frames back-to-back with no idle cycles -> three correct frames; no beat lost or duplicated; `tvalid` continuous apart from the 4-cycle start latency.
- Frame with random `s_axis_tvalid` gaps (50%) -> same output bytes and FCS as the gapless run; EMIT stays 4 contiguous cycles.
- 3-byte frame, then a 64-byte frame -> `runt_drop` pulses once, no output for the runt, and the 64-byte frame is correct.
- `rst_n` low at byte 30 of a frame with `SYNC_ON_RST`=1, then the rest of that frame, then a good frame -> all outputs 0 during reset; the remainder is discarded; the good frame is output correctly.

Source files
------------

// File: rtl/sm4_eth_fcs_regen_pkg.sv
// Shared definitions for the Ethernet FCS regeneration path: CRC-32 constants,
// FSM state encoding and the reflected byte-wise CRC step.
package sm4_eth_fcs_regen_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          HOLD_DEPTH    = 4;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_STREAM = 2'd1,
    ST_EMIT   = 2'd2
  } fcs_state_e;

  // Reflected CRC-32, LSB of the data byte enters first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sm4_eth_fcs_regen_crc.sv
// Combinational one-byte CRC-32 step, shared with FCS-check stages.
module eth_crc32_d8
  import sm4_eth_fcs_regen_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_byte(crc_in, data_in);

endmodule

// File: rtl/sm4_eth_fcs_regen.sv
// Recomputes the Ethernet FCS behind a 4-byte hold buffer and replaces the
// stale trailing 4 bytes of every frame; no backpressure.
module sm4_eth_fcs_regen
  import sm4_eth_fcs_regen_pkg::*;
#(
  parameter bit SYNC_ON_RST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic [7:0] s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic [7:0] m_axis_tuser,
  output logic       runt_drop
);

  localparam fcs_state_e RST_STATE = SYNC_ON_RST ? ST_SYNC : ST_STREAM;

  fcs_state_e        state_q, state_d;
  logic [3:0][7:0]   hd_q, hd_d;
  logic [3:0][7:0]   hu_q, hu_d;
  logic [2:0]        hcnt_q, hcnt_d;
  logic [31:0]       crc_q, crc_d;
  logic [31:0]       fcs_q, fcs_d;
  logic [3:0][7:0]   fcs_user_q, fcs_user_d;
  logic [1:0]        ecnt_q, ecnt_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [7:0]        tuser_q, tuser_d;
  logic              runt_q, runt_d;
  logic [31:0]       crc_step;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (hd_q[0]),
    .crc_out (crc_step)
  );

  always_comb begin
    state_d    = state_q;
    hd_d       = hd_q;
    hu_d       = hu_q;
    hcnt_d     = hcnt_q;
    crc_d      = crc_q;
    fcs_d      = fcs_q;
    fcs_user_d = fcs_user_q;
    ecnt_d     = ecnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = tuser_q;
    runt_d     = 1'b0;

    if (s_axis_tvalid) begin
      if (state_q == ST_SYNC) begin
        if (s_axis_tlast) state_d = ST_STREAM;
      end else if (hcnt_q == 3'(HOLD_DEPTH)) begin
        // Full buffer: oldest byte leaves as payload, new beat enters at the tail.
        tvalid_d = 1'b1;
        tdata_d  = hd_q[0];
        tuser_d  = hu_q[0];
        hd_d     = {s_axis_tdata, hd_q[3:1]};
        hu_d     = {s_axis_tuser, hu_q[3:1]};
        crc_d    = crc_step;
        if (s_axis_tlast) begin
          fcs_d      = ~crc_step;
          fcs_user_d = {s_axis_tuser, hu_q[3:1]};
          crc_d      = CRC32_INIT;
          hcnt_d     = 3'd0;
          ecnt_d     = 2'd0;
          state_d    = ST_EMIT;
        end
      end else begin
        hd_d[hcnt_q[1:0]] = s_axis_tdata;
        hu_d[hcnt_q[1:0]] = s_axis_tuser;
        hcnt_d            = hcnt_q + 3'd1;
        if (s_axis_tlast) begin
          hcnt_d = 3'd0;
          runt_d = 1'b1;
        end
      end
    end

    // Buffer cannot be full while emitting, so the FCS bytes never collide with payload.
    if (state_q == ST_EMIT) begin
      tvalid_d = 1'b1;
      tdata_d  = fcs_q[{ecnt_q, 3'b000} +: 8];
      tuser_d  = fcs_user_q[ecnt_q];
      tlast_d  = (ecnt_q == 2'd3);
      ecnt_d   = ecnt_q + 2'd1;
      if (ecnt_q == 2'd3) state_d = ST_STREAM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      hd_q       <= '0;
      hu_q       <= '0;
      hcnt_q     <= 3'd0;
      crc_q      <= CRC32_INIT;
      fcs_q      <= '0;
      fcs_user_q <= '0;
      ecnt_q     <= 2'd0;
      tdata_q    <= 8'd0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 8'd0;
      runt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hd_q       <= hd_d;
      hu_q       <= hu_d;
      hcnt_q     <= hcnt_d;
      crc_q      <= crc_d;
      fcs_q      <= fcs_d;
      fcs_user_q <= fcs_user_d;
      ecnt_q     <= ecnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      runt_q     <= runt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign runt_drop     = runt_q;

endmodule

// File: tb/tb_sm4_eth_fcs_regen.sv
// Scoreboard bench for sm4_eth_fcs_regen (SYNC_ON_RST=1 instance).
module tb_sm4_eth_fcs_regen;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] u;
    logic       l;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic [7:0] s_axis_tuser;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic [7:0] m_axis_tuser;
  logic       runt_drop;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t      sb[$];
  beat_t      exp_b;
  logic [7:0] fd[$];
  logic [7:0] fu[$];
  logic [7:0] saved_d[$];
  logic [7:0] saved_u[$];

  int          vcnt = 0;
  int          runt_cnt = 0;
  int          run = 0;
  int          last_c = 0;
  int          tl_c = 0;
  int          tl_in_c = 0;
  logic [31:0] mcrc = 32'hFFFFFFFF;

  sm4_eth_fcs_regen #(.SYNC_ON_RST(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .runt_drop     (runt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Bit-serial reflected CRC-32 reference.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mcrc = 32'hFFFFFFFF;
      run  = 0;
    end else begin
      if (runt_drop) runt_cnt++;
      if (m_axis_tvalid) begin
        vcnt++;
        run++;
        last_c = cyc;
        mcrc = ref_crc(mcrc, m_axis_tdata);
        if (sb.size() == 0) begin
          chk("unexpected_beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, 17'd0);
        end else begin
          exp_b = sb.pop_front();
          chk("beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, exp_b);
        end
        if (m_axis_tlast) begin
          chk("residue", mcrc, 32'hDEBB20E3);
          chk("emit_contig", (run >= 5), 1);
          mcrc = 32'hFFFFFFFF;
          tl_c = cyc;
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic fill_random(input int len);
    fd.delete();
    fu.delete();
    for (int i = 0; i < len; i++) begin
      fd.push_back(8'($urandom));
      fu.push_back(8'($urandom));
    end
  endtask

  task automatic send_frame(input int gap_pct, input bit exp_out, input int stop_at,
                            input bit use_fixed, input logic [31:0] fixed_fcs);
    int          len;
    logic [31:0] c;
    logic [31:0] fcs;
    len = fd.size();
    if (exp_out && len >= 5) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
        c = ref_crc(c, fd[i]);
        sb.push_back({fd[i], fu[i], 1'b0});
      end
      fcs = use_fixed ? fixed_fcs : ~c;
      for (int k = 0; k < 4; k++)
        sb.push_back({fcs[8*k +: 8], fu[len-4+k], (k == 3)});
    end
    for (int i = 0; i < stop_at; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      @(negedge clk);
      s_axis_tdata  = fd[i];
      s_axis_tuser  = fu[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      if (i == len - 1) tl_in_c = cyc + 1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser, runt_drop}, 19'd0);
  endtask

  initial begin
    int v0, r0, start_c;
    rst_n         = 1'b0;
    s_axis_tdata  = 8'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 8'd0;
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("reset_out");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle_out");

    // Leftover frame after reset is discarded while syncing.
    v0 = vcnt; r0 = runt_cnt;
    fill_random(10);
    send_frame(0, 1'b0, 10, 1'b0, 32'd0);
    drain("drain_sync");
    chk("sync_no_out", vcnt - v0, 0);
    chk("sync_no_runt", runt_cnt - r0, 0);

    // Known vector: "123456789" then 4 stale FCS bytes.
    fill_random(13);
    for (int i = 0; i < 9; i++) fd[i] = 8'h31 + 8'(i);
    v0 = vcnt;
    send_frame(0, 1'b1, 13, 1'b1, 32'hCBF43926);
    drain("drain_known");
    chk("known_len", vcnt - v0, 13);
    chk("tlast_latency", tl_c - tl_in_c, 4);

    // 64-byte random frame, saved for the gapped rerun.
    fill_random(64);
    saved_d = fd;
    saved_u = fu;
    v0 = vcnt;
    send_frame(0, 1'b1, 64, 1'b0, 32'd0);
    drain("drain_64");
    chk("len_64", vcnt - v0, 64);

    // Three back-to-back frames.
    v0 = vcnt;
    @(negedge clk);
    start_c = cyc + 1;
    for (int f = 0; f < 3; f++) begin
      fill_random(64);
      send_frame(0, 1'b1, 64, 1'b0, 32'd0);
    end
    drain("drain_b2b");
    chk("b2b_count", vcnt - v0, 192);
    chk("b2b_span", last_c - start_c, 196);

    // Same frame with ~50% input gaps.
    fd = saved_d;
    fu = saved_u;
    v0 = vcnt;
    send_frame(50, 1'b1, 64, 1'b0, 32'd0);
    drain("drain_gap");
    chk("gap_len", vcnt - v0, 64);

    // Runt then a good frame, no gap between them.
    v0 = vcnt; r0 = runt_cnt;
    fill_random(3);
    send_frame(0, 1'b1, 3, 1'b0, 32'd0);
    fill_random(64);
    send_frame(0, 1'b1, 64, 1'b0, 32'd0);
    drain("drain_runt");
    chk("runt_pulses", runt_cnt - r0, 1);
    chk("runt_then_len", vcnt - v0, 64);

    // Reset at byte 30, rest of frame discarded, then a good frame.
    fill_random(64);
    send_frame(0, 1'b1, 30, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("midrst_out");
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    v0 = vcnt; r0 = runt_cnt;
    fill_random(34);
    send_frame(0, 1'b0, 34, 1'b0, 32'd0);
    drain("drain_rest");
    chk("rest_discarded", vcnt - v0, 0);
    fill_random(64);
    v0 = vcnt;
    send_frame(0, 1'b1, 64, 1'b0, 32'd0);
    drain("drain_after_rst");
    chk("after_rst_len", vcnt - v0, 64);
    chk("after_rst_no_runt", runt_cnt - r0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
